// File: rtl/ant_agent_pipe.sv
// ant_agent_pipe: registered per-channel ant agent for the router input path.
// Each input channel captures a packet, records the local hop, classifies it
// as normal / forward ant / backward ant and resolves a one-hot output request.
// The request is resolved locally (eject, backtrack) or through the adaptive
// selection handshake. The packet is then held until the switch grants it.
// Optional build macro: ANT_AGENT_PIPE_STATS_EN adds per-channel saturating
// counters on the o_stat_* ports. Without it those ports are tied to zero.

package ant_agent_pipe_pkg;

    localparam int X_NODES   = 4;
    localparam int Y_NODES   = 4;
    localparam int NUM_IN    = 5;
    localparam int NUM_OUT   = 5;
    localparam int MEM_DEPTH = 8;

    localparam int X_W   = $clog2(X_NODES);
    localparam int Y_W   = $clog2(Y_NODES);
    localparam int CNT_W = $clog2(MEM_DEPTH + 1);

    typedef logic [0:MEM_DEPTH-1][X_W-1:0] xmem_t;
    typedef logic [0:MEM_DEPTH-1][Y_W-1:0] ymem_t;

    typedef struct packed {
        logic [7:0]       payload;
        logic             ant;
        logic             backward;
        logic [X_W-1:0]   x_source;
        logic [Y_W-1:0]   y_source;
        logic [X_W-1:0]   x_dest;
        logic [Y_W-1:0]   y_dest;
        logic [CNT_W-1:0] num_memories;
        logic [CNT_W-1:0] b_num_memories;
        xmem_t            x_memory;
        ymem_t            y_memory;
        xmem_t            b_x_memory;
        ymem_t            b_y_memory;
        logic [4:0]       pheromone_value;
    } packet_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_WAIT_SEL = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

endpackage

module ant_agent_pipe
    import ant_agent_pipe_pkg::*;
#(
    parameter int X_LOC    = 0,
    parameter int Y_LOC    = 0,
    parameter int N_IN     = NUM_IN,
    parameter int N_OUT    = NUM_OUT,
    parameter int MAX_HOPS = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  packet_t [0:N_IN-1]            i_data,
    input  logic    [0:N_IN-1]            i_data_val,
    output logic    [0:N_IN-1]            o_data_ready,
    output packet_t [0:N_IN-1]            o_data,
    output logic    [0:N_IN-1]            o_data_val,
    output logic    [0:N_IN-1][0:N_OUT-1] o_output_req,
    input  logic    [0:N_IN-1]            i_grant,
    output logic    [0:N_IN-1]            o_sel_req,
    output logic    [0:N_IN-1][X_W-1:0]   o_sel_x_dest,
    output logic    [0:N_IN-1][Y_W-1:0]   o_sel_y_dest,
    output logic    [0:N_IN-1][X_W-1:0]   o_sel_x_source,
    input  logic    [0:N_IN-1]            i_sel_ack,
    input  logic    [0:N_IN-1][0:N_OUT-1] i_sel_dir,
    output logic    [0:N_IN-1]            o_update,
    output logic    [0:N_IN-1][X_W-1:0]   o_upd_x_dest,
    output logic    [0:N_IN-1][Y_W-1:0]   o_upd_y_dest,
    output logic    [0:N_IN-1][4:0]       o_upd_pheromone,
    output logic    [0:N_IN-1]            o_drop,
    output logic    [0:N_IN-1][15:0]      o_stat_normal,
    output logic    [0:N_IN-1][15:0]      o_stat_ant,
    output logic    [0:N_IN-1][15:0]      o_stat_drop
);

    localparam logic [X_W-1:0]   X_ME      = X_LOC[X_W-1:0];
    localparam logic [Y_W-1:0]   Y_ME      = Y_LOC[Y_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX   = MAX_HOPS[CNT_W-1:0];
    localparam logic [0:N_OUT-1] REQ_LOCAL = {1'b1, {(N_OUT-1){1'b0}}};

    // Memory helpers use a compare loop so the hop counter never acts as a
    // raw (possibly over-wide) array index.
    function automatic xmem_t put_x(input xmem_t mem, input logic [CNT_W-1:0] idx,
                                    input logic [X_W-1:0] val);
        xmem_t res;
        res = mem;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            if (k == int'(idx)) res[k] = val;
        end
        return res;
    endfunction

    function automatic ymem_t put_y(input ymem_t mem, input logic [CNT_W-1:0] idx,
                                    input logic [Y_W-1:0] val);
        ymem_t res;
        res = mem;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            if (k == int'(idx)) res[k] = val;
        end
        return res;
    endfunction

    function automatic logic [X_W-1:0] get_x(input xmem_t mem, input logic [CNT_W-1:0] idx);
        logic [X_W-1:0] res;
        res = '0;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            if (k == int'(idx)) res = mem[k];
        end
        return res;
    endfunction

    function automatic logic [Y_W-1:0] get_y(input ymem_t mem, input logic [CNT_W-1:0] idx);
        logic [Y_W-1:0] res;
        res = '0;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            if (k == int'(idx)) res = mem[k];
        end
        return res;
    endfunction

    // Minimal direction toward a neighbouring hop: X first (E/W), then Y (N/S).
    // Index order of the request vector: 0 local, 1 N, 2 E, 3 S, 4 W.
    function automatic logic [0:N_OUT-1] dir_to(input logic [X_W-1:0] tx,
                                                input logic [Y_W-1:0] ty);
        logic [0:N_OUT-1] r;
        r = '0;
        if (tx != X_ME) begin
            if (tx > X_ME) r[2] = 1'b1;
            else           r[4] = 1'b1;
        end else if (ty > Y_ME) begin
            r[1] = 1'b1;
        end else begin
            r[3] = 1'b1;
        end
        return r;
    endfunction

    for (genvar c = 0; c < N_IN; c++) begin : g_ch

        state_t           state_q, state_d;
        packet_t          pkt_q, pkt_d;
        logic [0:N_OUT-1] req_q, req_d;
        logic             drop_q, drop_d;
        logic             upd_q, upd_d;
        logic [X_W-1:0]   upd_x_q;
        logic [Y_W-1:0]   upd_y_q;
        logic [4:0]       upd_ph_q;

        logic             at_dest, at_src, found;
        logic [X_W-1:0]   hop_x;
        logic [Y_W-1:0]   hop_y;

        logic             ready_c, val_c, sel_c;
        logic             hold_grant;

        assign at_dest    = (pkt_q.x_dest == X_ME) && (pkt_q.y_dest == Y_ME);
        assign at_src     = (pkt_q.x_source == X_ME) && (pkt_q.y_source == Y_ME);
        assign hold_grant = (state_q == ST_HOLD) && i_grant[c];

        // Channel state register; reset abandons any in-flight packet silently.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) state_q <= ST_IDLE;
            else          state_q <= state_d;
        end

        // Next-state and decode: hop recording, ant conversion and request resolution.
        always_comb begin
            state_d = state_q;
            pkt_d   = pkt_q;
            req_d   = req_q;
            drop_d  = 1'b0;
            upd_d   = 1'b0;
            found   = 1'b0;
            hop_x   = '0;
            hop_y   = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_data_val[c]) begin
                        pkt_d   = i_data[c];
                        req_d   = '0;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!pkt_q.backward) begin
                        if (pkt_q.num_memories == CNT_MAX) begin
                            drop_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            pkt_d.x_memory     = put_x(pkt_q.x_memory, pkt_q.num_memories, X_ME);
                            pkt_d.y_memory     = put_y(pkt_q.y_memory, pkt_q.num_memories, Y_ME);
                            pkt_d.num_memories = pkt_q.num_memories + 1'b1;
                            if (!at_dest) begin
                                state_d = ST_WAIT_SEL;
                            end else if (!pkt_q.ant) begin
                                req_d   = REQ_LOCAL;
                                state_d = ST_HOLD;
                            end else begin
                                pkt_d.backward = 1'b1;
                                pkt_d.x_source = pkt_q.x_dest;
                                pkt_d.y_source = pkt_q.y_dest;
                                pkt_d.x_dest   = pkt_q.x_source;
                                pkt_d.y_dest   = pkt_q.y_source;
                                if (pkt_q.b_num_memories == CNT_MAX) begin
                                    drop_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    pkt_d.b_x_memory     = put_x(pkt_q.b_x_memory, pkt_q.b_num_memories, X_ME);
                                    pkt_d.b_y_memory     = put_y(pkt_q.b_y_memory, pkt_q.b_num_memories, Y_ME);
                                    pkt_d.b_num_memories = pkt_q.b_num_memories + 1'b1;
                                    if (pkt_q.x_source == pkt_q.x_dest && pkt_q.y_source == pkt_q.y_dest) begin
                                        req_d   = REQ_LOCAL;
                                        state_d = ST_HOLD;
                                    end else if (pkt_q.num_memories == '0) begin
                                        drop_d  = 1'b1;
                                        state_d = ST_IDLE;
                                    end else begin
                                        // Previous hop sits just before the entry written this cycle.
                                        hop_x   = get_x(pkt_q.x_memory, pkt_q.num_memories - 1'b1);
                                        hop_y   = get_y(pkt_q.y_memory, pkt_q.num_memories - 1'b1);
                                        req_d   = dir_to(hop_x, hop_y);
                                        state_d = ST_HOLD;
                                    end
                                end
                            end
                        end
                    end else begin
                        if (pkt_q.b_num_memories == CNT_MAX) begin
                            drop_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            pkt_d.b_x_memory     = put_x(pkt_q.b_x_memory, pkt_q.b_num_memories, X_ME);
                            pkt_d.b_y_memory     = put_y(pkt_q.b_y_memory, pkt_q.b_num_memories, Y_ME);
                            pkt_d.b_num_memories = pkt_q.b_num_memories + 1'b1;
                            upd_d                = !at_src;
                            if (at_dest) begin
                                req_d   = REQ_LOCAL;
                                state_d = ST_HOLD;
                            end else begin
                                // Latest occurrence of this node wins so loops in the path are skipped.
                                for (int m = 1; m < MAX_HOPS; m++) begin
                                    if (m < int'(pkt_q.num_memories) &&
                                        pkt_q.x_memory[m] == X_ME && pkt_q.y_memory[m] == Y_ME) begin
                                        found = 1'b1;
                                        hop_x = pkt_q.x_memory[m-1];
                                        hop_y = pkt_q.y_memory[m-1];
                                    end
                                end
                                if (found) begin
                                    req_d   = dir_to(hop_x, hop_y);
                                    state_d = ST_HOLD;
                                end else begin
                                    drop_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            end
                        end
                    end
                end
                ST_WAIT_SEL: begin
                    if (i_sel_ack[c]) begin
                        if ($onehot(i_sel_dir[c])) begin
                            req_d   = i_sel_dir[c];
                            state_d = ST_HOLD;
                        end else begin
                            drop_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_grant[c]) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Packet/request registers and the one-cycle strobes with their payload.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pkt_q    <= '0;
                req_q    <= '0;
                drop_q   <= 1'b0;
                upd_q    <= 1'b0;
                upd_x_q  <= '0;
                upd_y_q  <= '0;
                upd_ph_q <= '0;
            end else begin
                pkt_q  <= pkt_d;
                req_q  <= req_d;
                drop_q <= drop_d;
                upd_q  <= upd_d;
                if (upd_d) begin
                    upd_x_q  <= pkt_q.x_source;
                    upd_y_q  <= pkt_q.y_source;
                    upd_ph_q <= pkt_q.pheromone_value;
                end
            end
        end

        // Handshake outputs decoded from the current state.
        always_comb begin
            ready_c = (state_q == ST_IDLE);
            val_c   = (state_q == ST_HOLD);
            sel_c   = (state_q == ST_WAIT_SEL);
        end

        assign o_data_ready[c]    = ready_c;
        assign o_data_val[c]      = val_c;
        assign o_data[c]          = val_c ? pkt_q : '0;
        assign o_output_req[c]    = val_c ? req_q : '0;
        assign o_sel_req[c]       = sel_c;
        assign o_sel_x_dest[c]    = sel_c ? pkt_q.x_dest   : '0;
        assign o_sel_y_dest[c]    = sel_c ? pkt_q.y_dest   : '0;
        assign o_sel_x_source[c]  = sel_c ? pkt_q.x_source : '0;
        assign o_update[c]        = upd_q;
        assign o_upd_x_dest[c]    = upd_q ? upd_x_q  : '0;
        assign o_upd_y_dest[c]    = upd_q ? upd_y_q  : '0;
        assign o_upd_pheromone[c] = upd_q ? upd_ph_q : '0;
        assign o_drop[c]          = drop_q;

`ifdef ANT_AGENT_PIPE_STATS_EN
        logic [15:0] stat_normal_q, stat_ant_q, stat_drop_q;

        // Saturating event counters: granted normals, granted ants, drops.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stat_normal_q <= '0;
                stat_ant_q    <= '0;
                stat_drop_q   <= '0;
            end else begin
                if (hold_grant && !pkt_q.ant && stat_normal_q != 16'hFFFF)
                    stat_normal_q <= stat_normal_q + 16'd1;
                if (hold_grant && pkt_q.ant && stat_ant_q != 16'hFFFF)
                    stat_ant_q <= stat_ant_q + 16'd1;
                if (drop_d && stat_drop_q != 16'hFFFF)
                    stat_drop_q <= stat_drop_q + 16'd1;
            end
        end

        assign o_stat_normal[c] = stat_normal_q;
        assign o_stat_ant[c]    = stat_ant_q;
        assign o_stat_drop[c]   = stat_drop_q;
`else
        logic unused_stat;
        assign unused_stat      = hold_grant;
        assign o_stat_normal[c] = '0;
        assign o_stat_ant[c]    = '0;
        assign o_stat_drop[c]   = '0;
`endif
    end

endmodule

// File: tb/tb_ant_agent_pipe.sv
// Directed self-checking bench for ant_agent_pipe at node (1,1), 5 channels.
// Request vectors are written index 0 first: 10000 local, 00100 E, 00001 W.
// Stat checks follow ANT_AGENT_PIPE_STATS_EN (zero when the macro is off).

module tb_ant_agent_pipe;
    import ant_agent_pipe_pkg::*;

    logic                 clk;
    logic                 reset_n;
    packet_t [0:4]        i_data;
    logic    [0:4]        i_data_val;
    logic    [0:4]        o_data_ready;
    packet_t [0:4]        o_data;
    logic    [0:4]        o_data_val;
    logic    [0:4][0:4]   o_output_req;
    logic    [0:4]        i_grant;
    logic    [0:4]        o_sel_req;
    logic    [0:4][X_W-1:0] o_sel_x_dest;
    logic    [0:4][Y_W-1:0] o_sel_y_dest;
    logic    [0:4][X_W-1:0] o_sel_x_source;
    logic    [0:4]        i_sel_ack;
    logic    [0:4][0:4]   i_sel_dir;
    logic    [0:4]        o_update;
    logic    [0:4][X_W-1:0] o_upd_x_dest;
    logic    [0:4][Y_W-1:0] o_upd_y_dest;
    logic    [0:4][4:0]   o_upd_pheromone;
    logic    [0:4]        o_drop;
    logic    [0:4][15:0]  o_stat_normal;
    logic    [0:4][15:0]  o_stat_ant;
    logic    [0:4][15:0]  o_stat_drop;

    int n_checks = 0;
    int n_fail   = 0;

    ant_agent_pipe #(
        .X_LOC(1), .Y_LOC(1), .N_IN(5), .N_OUT(5), .MAX_HOPS(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_data(i_data), .i_data_val(i_data_val), .o_data_ready(o_data_ready),
        .o_data(o_data), .o_data_val(o_data_val), .o_output_req(o_output_req),
        .i_grant(i_grant), .o_sel_req(o_sel_req),
        .o_sel_x_dest(o_sel_x_dest), .o_sel_y_dest(o_sel_y_dest),
        .o_sel_x_source(o_sel_x_source), .i_sel_ack(i_sel_ack), .i_sel_dir(i_sel_dir),
        .o_update(o_update), .o_upd_x_dest(o_upd_x_dest), .o_upd_y_dest(o_upd_y_dest),
        .o_upd_pheromone(o_upd_pheromone), .o_drop(o_drop),
        .o_stat_normal(o_stat_normal), .o_stat_ant(o_stat_ant), .o_stat_drop(o_stat_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one packet for one cycle; returns at the negedge after capture.
    task automatic applyStimulus(input int ch, input packet_t p);
        i_data[ch]     = p;
        i_data_val[ch] = 1'b1;
        tick();
        i_data_val[ch] = 1'b0;
    endtask

    function automatic packet_t make_pkt(input logic ant, input logic bwd,
                                         input int xs, input int ys, input int xd, input int yd,
                                         input int num, input int bnum, input int ph);
        packet_t p;
        p                = '0;
        p.payload        = 8'hA5;
        p.ant            = ant;
        p.backward       = bwd;
        p.x_source       = X_W'(xs);
        p.y_source       = Y_W'(ys);
        p.x_dest         = X_W'(xd);
        p.y_dest         = Y_W'(yd);
        p.num_memories   = CNT_W'(num);
        p.b_num_memories = CNT_W'(bnum);
        p.pheromone_value = 5'(ph);
        return p;
    endfunction

    initial begin
        packet_t     p;
        logic [0:4]  exp_val;

        reset_n    = 1'b0;
        i_data     = '0;
        i_data_val = '0;
        i_grant    = '0;
        i_sel_ack  = '0;
        i_sel_dir  = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 64'(o_data_ready), 64'h1F);
        checkOutput("reset_val", 64'(o_data_val), 64'h0);
        checkOutput("reset_sel", 64'(o_sel_req), 64'h0);
        checkOutput("reset_drop", 64'(o_drop), 64'h0);
        checkOutput("reset_data0", 64'(o_data[0].num_memories), 64'h0);
        reset_n = 1'b1;
        tick();

        // Normal packet at its destination on channel 2: local eject.
        p = make_pkt(1'b0, 1'b0, 0, 0, 1, 1, 2, 0, 0);
        p.x_memory[0] = 2'd0; p.y_memory[0] = 2'd1;
        p.x_memory[1] = 2'd1; p.y_memory[1] = 2'd0;
        applyStimulus(2, p);
        checkOutput("t1_decode_val", 64'(o_data_val[2]), 64'h0);
        checkOutput("t1_decode_ready", 64'(o_data_ready[2]), 64'h0);
        tick();
        checkOutput("t1_val", 64'(o_data_val[2]), 64'h1);
        checkOutput("t1_req", 64'(o_output_req[2]), 64'(5'b10000));
        checkOutput("t1_num", 64'(o_data[2].num_memories), 64'h3);
        checkOutput("t1_mem_x", 64'(o_data[2].x_memory[2]), 64'h1);
        checkOutput("t1_mem_y", 64'(o_data[2].y_memory[2]), 64'h1);
        i_grant[2] = 1'b1;
        tick();
        i_grant[2] = 1'b0;
        checkOutput("t1_ready_after", 64'(o_data_ready[2]), 64'h1);
        checkOutput("t1_req_cleared", 64'(o_output_req[2]), 64'h0);

        // Adaptive path on channel 0: selection handshake, then a bad ack.
        p = make_pkt(1'b0, 1'b0, 2, 0, 3, 1, 0, 0, 0);
        applyStimulus(0, p);
        tick();
        checkOutput("t2_sel_req", 64'(o_sel_req[0]), 64'h1);
        checkOutput("t2_sel_xd", 64'(o_sel_x_dest[0]), 64'h3);
        checkOutput("t2_sel_yd", 64'(o_sel_y_dest[0]), 64'h1);
        checkOutput("t2_sel_xs", 64'(o_sel_x_source[0]), 64'h2);
        tick();
        tick();
        tick();
        checkOutput("t2_sel_held", 64'(o_sel_req[0]), 64'h1);
        i_sel_ack[0] = 1'b1;
        i_sel_dir[0] = 5'b00100;
        tick();
        i_sel_ack[0] = 1'b0;
        i_sel_dir[0] = '0;
        checkOutput("t2_sel_off", 64'(o_sel_req[0]), 64'h0);
        checkOutput("t2_val", 64'(o_data_val[0]), 64'h1);
        checkOutput("t2_req", 64'(o_output_req[0]), 64'(5'b00100));
        i_grant[0] = 1'b1;
        tick();
        i_grant[0] = 1'b0;
        applyStimulus(0, p);
        tick();
        i_sel_ack[0] = 1'b1;
        i_sel_dir[0] = 5'b00000;
        tick();
        i_sel_ack[0] = 1'b0;
        checkOutput("t2_bad_ack_drop", 64'(o_drop[0]), 64'h1);
        checkOutput("t2_bad_ack_ready", 64'(o_data_ready[0]), 64'h1);
        tick();
        checkOutput("t2_drop_pulse", 64'(o_drop[0]), 64'h0);

        // Forward ant reaches destination on channel 1 and turns backward.
        p = make_pkt(1'b1, 1'b0, 0, 1, 1, 1, 1, 0, 0);
        p.x_memory[0] = 2'd0; p.y_memory[0] = 2'd1;
        applyStimulus(1, p);
        tick();
        checkOutput("t3_val", 64'(o_data_val[1]), 64'h1);
        checkOutput("t3_backward", 64'(o_data[1].backward), 64'h1);
        checkOutput("t3_dest", 64'({o_data[1].x_dest, o_data[1].y_dest}), 64'h1);
        checkOutput("t3_src", 64'({o_data[1].x_source, o_data[1].y_source}), 64'h5);
        checkOutput("t3_req", 64'(o_output_req[1]), 64'(5'b00001));
        checkOutput("t3_bnum", 64'(o_data[1].b_num_memories), 64'h1);
        i_grant[1] = 1'b1;
        tick();
        i_grant[1] = 1'b0;

        // Backward ant on channel 3: update strobe and backtrack west.
        p = make_pkt(1'b1, 1'b1, 2, 1, 0, 1, 3, 1, 19);
        p.x_memory[0] = 2'd0; p.y_memory[0] = 2'd1;
        p.x_memory[1] = 2'd1; p.y_memory[1] = 2'd1;
        p.x_memory[2] = 2'd2; p.y_memory[2] = 2'd1;
        applyStimulus(3, p);
        tick();
        checkOutput("t4_update", 64'(o_update[3]), 64'h1);
        checkOutput("t4_upd_key", 64'({o_upd_x_dest[3], o_upd_y_dest[3]}), 64'h9);
        checkOutput("t4_upd_ph", 64'(o_upd_pheromone[3]), 64'd19);
        checkOutput("t4_req", 64'(o_output_req[3]), 64'(5'b00001));
        checkOutput("t4_bnum", 64'(o_data[3].b_num_memories), 64'h2);
        i_grant[3] = 1'b1;
        tick();
        i_grant[3] = 1'b0;
        checkOutput("t4_update_pulse", 64'(o_update[3]), 64'h0);
        p.x_memory[1] = 2'd2; p.y_memory[1] = 2'd2;
        applyStimulus(3, p);
        tick();
        checkOutput("t4_nomatch_drop", 64'(o_drop[3]), 64'h1);
        checkOutput("t4_nomatch_ready", 64'(o_data_ready[3]), 64'h1);

        // Hop memory already full on channel 4.
        p = make_pkt(1'b0, 1'b0, 0, 0, 3, 3, 8, 0, 0);
        applyStimulus(4, p);
        tick();
        checkOutput("t5_full_drop", 64'(o_drop[4]), 64'h1);
        checkOutput("t5_full_val", 64'(o_data_val[4]), 64'h0);
        tick();
`ifdef ANT_AGENT_PIPE_STATS_EN
        checkOutput("t5_stat_drop4", 64'(o_stat_drop[4]), 64'd1);
        checkOutput("t5_stat_normal2", 64'(o_stat_normal[2]), 64'd1);
        checkOutput("t5_stat_ant3", 64'(o_stat_ant[3]), 64'd1);
`else
        checkOutput("t5_stat_drop4", 64'(o_stat_drop[4]), 64'd0);
        checkOutput("t5_stat_normal2", 64'(o_stat_normal[2]), 64'd0);
        checkOutput("t5_stat_ant3", 64'(o_stat_ant[3]), 64'd0);
`endif

        // All channels loaded at once, granted one per cycle.
        for (int c = 0; c < 5; c++) begin
            i_data[c]     = make_pkt(1'b0, 1'b0, 0, 0, 1, 1, c, 0, 0);
            i_data_val[c] = 1'b1;
        end
        tick();
        i_data_val = '0;
        tick();
        checkOutput("t6_all_val", 64'(o_data_val), 64'h1F);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("t6_num_ch%0d", c), 64'(o_data[c].num_memories), 64'(c + 1));
        end
        for (int s = 0; s < 5; s++) begin
            i_grant    = '0;
            i_grant[s] = 1'b1;
            tick();
            for (int k = 0; k < 5; k++) exp_val[k] = (k > s);
            checkOutput($sformatf("t6_val_step%0d", s), 64'(o_data_val), 64'(exp_val));
        end
        i_grant = '0;

        // Asynchronous reset while waiting for selection.
        p = make_pkt(1'b0, 1'b0, 2, 0, 3, 1, 0, 0, 0);
        applyStimulus(0, p);
        tick();
        checkOutput("t7_waiting", 64'(o_sel_req[0]), 64'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("t7_sel_off", 64'(o_sel_req[0]), 64'h0);
        checkOutput("t7_ready", 64'(o_data_ready), 64'h1F);
        checkOutput("t7_no_drop", 64'(o_drop), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkOutput("t7_no_drop_after", 64'(o_drop), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
